// File: rtl/tlb_assoc_pcid_pkg.sv
// tlb_pkg: shared configuration, derived widths, entry layout, FSM state and
// address/match helpers for the set-associative PCID-tagged TLB.
// Geometry is configured here (VA_W, PA_W, PCID_W, PAGE_BITS, SETS, WAYS);
// SETS and WAYS must be powers of two and >= 2.
// Optional feature macro: TLB_GLOBAL_EN (adds a per-entry global bit).
package tlb_pkg;

  localparam int VA_W      = 64;
  localparam int PA_W      = 64;
  localparam int PCID_W    = 12;
  localparam int PAGE_BITS = 12;
  localparam int SETS      = 8;
  localparam int WAYS      = 8;

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = VA_W - PAGE_BITS - IDX_W;
  localparam int PPN_W = PA_W - PAGE_BITS;

  typedef struct packed {
    logic              valid;
`ifdef TLB_GLOBAL_EN
    logic              g;
`endif
    logic [PCID_W-1:0] pcid;
    logic [TAG_W-1:0]  tag;
    logic [PPN_W-1:0]  ppn;
  } tlb_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } tlb_state_t;

  function automatic logic [IDX_W-1:0] va_idx(logic [VA_W-1:0] va);
    return va[PAGE_BITS +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] va_tag(logic [VA_W-1:0] va);
    return va[VA_W-1 -: TAG_W];
  endfunction

  // Global entries ignore the PCID qualifier when the feature is built in.
  function automatic logic entry_match(tlb_entry_t e, logic [TAG_W-1:0] tag,
                                       logic [PCID_W-1:0] pcid);
`ifdef TLB_GLOBAL_EN
    return e.valid && (e.tag == tag) && ((e.pcid == pcid) || e.g);
`else
    return e.valid && (e.tag == tag) && (e.pcid == pcid);
`endif
  endfunction

endpackage

// File: rtl/tlb_assoc_pcid_if.sv
// tlb_assoc_pcid_if: lookup, fill and flush handshake bundle of the TLB.
//   master: AGU / page walker side (drives requests, fills, flushes)
//   slave : TLB side (drives ready, registered response, flush_busy)
interface tlb_assoc_pcid_if;
  import tlb_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [VA_W-1:0]   req_va;
  logic [PCID_W-1:0] req_pcid;

  logic              resp_valid;
  logic              resp_hit;
  logic              resp_miss;
  logic [PA_W-1:0]   resp_pa;

  logic              ins_valid;
  logic              ins_ready;
  logic [VA_W-1:0]   ins_va;
  logic [PA_W-1:0]   ins_pa;
  logic [PCID_W-1:0] ins_pcid;
  logic              ins_global;

  logic              flush_valid;
  logic              flush_all;
  logic [PCID_W-1:0] flush_pcid;
  logic              flush_busy;

  modport master (
    output req_valid, req_va, req_pcid,
    output ins_valid, ins_va, ins_pa, ins_pcid, ins_global,
    output flush_valid, flush_all, flush_pcid,
    input  req_ready, resp_valid, resp_hit, resp_miss, resp_pa,
    input  ins_ready, flush_busy
  );

  modport slave (
    input  req_valid, req_va, req_pcid,
    input  ins_valid, ins_va, ins_pa, ins_pcid, ins_global,
    input  flush_valid, flush_all, flush_pcid,
    output req_ready, resp_valid, resp_hit, resp_miss, resp_pa,
    output ins_ready, flush_busy
  );

endinterface

// File: rtl/tlb_plru_tree.sv
// tlb_plru_tree: combinational tree pseudo-LRU for one set.
//   plru_i       WAYS-1 node bits, heap order (node n -> children 2n+1, 2n+2)
//   access_way_i way being hit or written
//   victim_o     way the tree currently points at
//   plru_next_o  node bits after access_way_i, each path node pointing away
// A node bit of 0 points left (lower ways), 1 points right.
module tlb_plru_tree #(
  parameter int WAYS  = 8,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_i,
  input  logic [WAY_W-1:0] access_way_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [WAYS-2:0]  plru_next_o
);

  // Follow the node bits from the root to a leaf to find the victim.
  always_comb begin
    logic [WAY_W-1:0] node;
    node     = '0;
    victim_o = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_o[WAY_W-1-l] = plru_i[node];
      node = WAY_W'(2 * int'(node) + 1 + int'(plru_i[node]));
    end
  end

  // Walk the accessed way's path, pointing each node at the other subtree.
  always_comb begin
    logic [WAY_W-1:0] node;
    node        = '0;
    plru_next_o = plru_i;
    for (int l = 0; l < WAY_W; l++) begin
      plru_next_o[node] = ~access_way_i[WAY_W-1-l];
      node = WAY_W'(2 * int'(node) + 1 + int'(access_way_i[WAY_W-1-l]));
    end
  end

endmodule

// File: rtl/tlb_assoc_pcid.sv
// tlb_assoc_pcid: set-associative, PCID-tagged TLB between AGU and walker.
//   clk, shutdown_n (async active-low reset)
//   bus (slave): lookup req/resp (response registered one cycle after
//   accept), single-cycle fill with no duplicates, per-PCID / full flush FSM
//   that sweeps one set per cycle. Priority: flush > insert > lookup.
// Optional feature macro: TLB_GLOBAL_EN (global pages match any PCID and
// survive per-PCID flushes).
module tlb_assoc_pcid
  import tlb_pkg::*;
(
  input logic             clk,
  input logic             shutdown_n,
  tlb_assoc_pcid_if.slave bus
);

  tlb_entry_t        entries_q [SETS][WAYS];
  tlb_entry_t        entries_d [SETS][WAYS];
  logic [WAYS-2:0]   plru_q    [SETS];
  logic [WAYS-2:0]   plru_d    [SETS];
  tlb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              flush_all_q, flush_all_d;
  logic [PCID_W-1:0] flush_pcid_q, flush_pcid_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic              resp_miss_q, resp_miss_d;
  logic [PA_W-1:0]   resp_pa_q, resp_pa_d;

  logic              req_fire_s, ins_fire_s;
  logic [IDX_W-1:0]  req_idx_s, ins_idx_s, plru_set_s;
  logic [TAG_W-1:0]  req_tag_s, ins_tag_s;
  logic              req_hit_s, ins_hit_s, inv_found_s;
  logic [WAY_W-1:0]  req_way_s, ins_hit_way_s, inv_way_s, ins_way_s;
  logic [WAY_W-1:0]  access_way_s, victim_s;
  logic [WAYS-2:0]   plru_next_s;
  tlb_entry_t        new_entry_s;
  logic              unused_s;

  // Offset bits of the fill PA never reach storage; global flag only when built in.
  assign unused_s = ^{bus.ins_pa[PAGE_BITS-1:0], bus.ins_global};

  assign bus.req_ready  = shutdown_n && (state_q == IDLE) && !bus.ins_valid;
  assign bus.ins_ready  = shutdown_n && (state_q == IDLE) && !bus.flush_valid;
  assign bus.flush_busy = (state_q == FLUSH);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_miss  = resp_miss_q;
  assign bus.resp_pa    = resp_pa_q;

  assign req_fire_s = bus.req_valid && bus.req_ready;
  assign ins_fire_s = bus.ins_valid && bus.ins_ready;
  assign req_idx_s  = va_idx(bus.req_va);
  assign req_tag_s  = va_tag(bus.req_va);
  assign ins_idx_s  = va_idx(bus.ins_va);
  assign ins_tag_s  = va_tag(bus.ins_va);

  // Lookup tag compare; lowest matching way wins.
  always_comb begin
    req_hit_s = 1'b0;
    req_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entry_match(entries_q[req_idx_s][w], req_tag_s, bus.req_pcid)) begin
        req_hit_s = 1'b1;
        req_way_s = WAY_W'(w);
      end else begin
      end
    end
  end

  // Fill way selection: existing match, else lowest invalid, else PLRU victim.
  always_comb begin
    ins_hit_s     = 1'b0;
    ins_hit_way_s = '0;
    inv_found_s   = 1'b0;
    inv_way_s     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entry_match(entries_q[ins_idx_s][w], ins_tag_s, bus.ins_pcid)) begin
        ins_hit_s     = 1'b1;
        ins_hit_way_s = WAY_W'(w);
      end else begin
      end
      if (!entries_q[ins_idx_s][w].valid) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
      end
    end
    if (ins_hit_s) begin
      ins_way_s = ins_hit_way_s;
    end else if (inv_found_s) begin
      ins_way_s = inv_way_s;
    end else begin
      ins_way_s = victim_s;
    end
  end

  // Insert and lookup never fire together, so one PLRU port serves both.
  assign plru_set_s   = ins_fire_s ? ins_idx_s : req_idx_s;
  assign access_way_s = ins_fire_s ? ins_way_s : req_way_s;

  tlb_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_i       (plru_q[plru_set_s]),
    .access_way_i (access_way_s),
    .victim_o     (victim_s),
    .plru_next_o  (plru_next_s)
  );

  // Entry image written by an accepted fill.
  always_comb begin
    new_entry_s       = '0;
    new_entry_s.valid = 1'b1;
`ifdef TLB_GLOBAL_EN
    new_entry_s.g     = bus.ins_global;
`endif
    new_entry_s.pcid  = bus.ins_pcid;
    new_entry_s.tag   = ins_tag_s;
    new_entry_s.ppn   = bus.ins_pa[PA_W-1:PAGE_BITS];
  end

  // Next state: flush sweep, fill write, lookup response and PLRU update.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_all_d  = flush_all_q;
    flush_pcid_d = flush_pcid_q;
    entries_d    = entries_q;
    plru_d       = plru_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_miss_d  = 1'b0;
    resp_pa_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.flush_valid) begin
          state_d      = FLUSH;
          flush_cnt_d  = '0;
          flush_all_d  = bus.flush_all;
          flush_pcid_d = bus.flush_pcid;
        end else begin
        end
      end
      FLUSH: begin
        for (int w = 0; w < WAYS; w++) begin
`ifdef TLB_GLOBAL_EN
          if (flush_all_q || ((entries_q[flush_cnt_q][w].pcid == flush_pcid_q) &&
                              !entries_q[flush_cnt_q][w].g)) begin
`else
          if (flush_all_q || (entries_q[flush_cnt_q][w].pcid == flush_pcid_q)) begin
`endif
            entries_d[flush_cnt_q][w].valid = 1'b0;
          end else begin
          end
        end
        if (flush_cnt_q == IDX_W'(SETS - 1)) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ins_fire_s) begin
      entries_d[ins_idx_s][ins_way_s] = new_entry_s;
      plru_d[ins_idx_s]               = plru_next_s;
    end else if (req_fire_s) begin
      resp_valid_d = 1'b1;
      resp_miss_d  = !req_hit_s;
      if (req_hit_s) begin
        resp_hit_d        = 1'b1;
        resp_pa_d         = {entries_q[req_idx_s][req_way_s].ppn,
                             bus.req_va[PAGE_BITS-1:0]};
        plru_d[req_idx_s] = plru_next_s;
      end else begin
      end
    end else begin
    end
  end

  // State registers; reset invalidates every entry and aborts any flush.
  always_ff @(posedge clk or negedge shutdown_n) begin
    if (!shutdown_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          entries_q[s][w] <= '0;
        end
      end
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      flush_all_q  <= 1'b0;
      flush_pcid_q <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_miss_q  <= 1'b0;
      resp_pa_q    <= '0;
    end else begin
      entries_q    <= entries_d;
      plru_q       <= plru_d;
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_all_q  <= flush_all_d;
      flush_pcid_q <= flush_pcid_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_miss_q  <= resp_miss_d;
      resp_pa_q    <= resp_pa_d;
    end
  end

endmodule

// File: tb/tb_tlb_assoc_pcid.sv
// Scoreboard bench for tlb_assoc_pcid: directed scenarios plus random traffic
// against a behavioural model (page-number matching, timestamp-based tree-PLRU).
module tb_tlb_assoc_pcid;
  import tlb_pkg::*;

  logic clk = 1'b0;
  logic shutdown_n;
  always #5 clk = ~clk;

  tlb_assoc_pcid_if bus ();
  tlb_assoc_pcid dut (.clk(clk), .shutdown_n(shutdown_n), .bus(bus));

  int checks = 0;
  int passes = 0;

  typedef struct packed { logic hit; logic [63:0] pa; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: one record per (set, way).
  bit              m_valid [SETS][WAYS];
  bit              m_g     [SETS][WAYS];
  int unsigned     m_pcid  [SETS][WAYS];
  longint unsigned m_vpn   [SETS][WAYS];
  longint unsigned m_ppn   [SETS][WAYS];
  longint unsigned m_stamp [SETS][WAYS];
  longint unsigned now_t;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_g[s][w] = 0; m_stamp[s][w] = 0;
      end
    now_t = 0;
  endfunction

  function automatic int m_set(longint unsigned va);
    return int'((va >> PAGE_BITS) % longint'(SETS));
  endfunction

  function automatic bit m_match(int s, int w, longint unsigned vpn, int unsigned pcid);
    return m_valid[s][w] && (m_vpn[s][w] == vpn) && ((m_pcid[s][w] == pcid) || m_g[s][w]);
  endfunction

  // Tree-PLRU: each node points away from the half holding the latest access.
  function automatic int m_victim(int s);
    int lo = 0, hi = WAYS;
    while (hi - lo > 1) begin
      int mid = (lo + hi) / 2;
      int best = -1;
      longint unsigned bs = 0;
      for (int w = lo; w < hi; w++)
        if (m_stamp[s][w] > bs) begin bs = m_stamp[s][w]; best = w; end
      if (best >= 0 && best < mid) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic exp_t m_lookup(longint unsigned va, int unsigned pcid);
    exp_t e;
    int s = m_set(va);
    e.hit = 1'b0; e.pa = 64'h0;
    for (int w = 0; w < WAYS; w++)
      if (!e.hit && m_match(s, w, va >> PAGE_BITS, pcid)) begin
        e.hit = 1'b1;
        e.pa = (m_ppn[s][w] << PAGE_BITS) | (va & 64'hFFF);
        now_t++; m_stamp[s][w] = now_t;
      end
    return e;
  endfunction

  function automatic void m_insert(longint unsigned va, longint unsigned pa,
                                   int unsigned pcid, bit g);
    int s = m_set(va);
    int way = -1;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && m_match(s, w, va >> PAGE_BITS, pcid)) way = w;
    for (int w = 0; w < WAYS; w++)
      if (way < 0 && !m_valid[s][w]) way = w;
    if (way < 0) way = m_victim(s);
    m_valid[s][way] = 1;
`ifdef TLB_GLOBAL_EN
    m_g[s][way] = g;
`else
    m_g[s][way] = 0 & g;
`endif
    m_pcid[s][way] = pcid;
    m_vpn[s][way] = va >> PAGE_BITS;
    m_ppn[s][way] = pa >> PAGE_BITS;
    now_t++; m_stamp[s][way] = now_t;
  endfunction

  function automatic void m_flush(bit all, int unsigned pcid);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (all || (m_pcid[s][w] == pcid && !m_g[s][w])) m_valid[s][w] = 0;
  endfunction

  // Monitor: every presented response is popped and compared.
  always @(negedge clk) begin
    if (bus.resp_valid || bus.resp_miss) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected: got valid=%b hit=%b pa=%h expected no response",
                 bus.resp_valid, bus.resp_hit, bus.resp_pa);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.resp_valid === 1'b1 && bus.resp_hit === mon_e.hit &&
            bus.resp_miss === !mon_e.hit && bus.resp_pa === mon_e.pa)
          passes++;
        else
          $display("FAIL resp: got v=%b hit=%b miss=%b pa=%h expected hit=%b pa=%h",
                   bus.resp_valid, bus.resp_hit, bus.resp_miss, bus.resp_pa,
                   mon_e.hit, mon_e.pa);
      end
    end
  end

  task automatic do_lookup(logic [63:0] va, logic [11:0] pcid);
    int n = 0;
    bit ok = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_va = va; bus.req_pcid = pcid;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1; else n++;
    end
    if (ok) exp_q.push_back(m_lookup(va, pcid));
    else begin checks++; $display("FAIL lookup_timeout: got ready=0 expected ready=1"); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_insert(logic [63:0] va, logic [63:0] pa, logic [11:0] pcid, bit g);
    int n = 0;
    bit ok = 0;
    @(posedge clk); #1;
    bus.ins_valid = 1'b1; bus.ins_va = va; bus.ins_pa = pa;
    bus.ins_pcid = pcid; bus.ins_global = g;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.ins_ready) ok = 1; else n++;
    end
    if (ok) m_insert(va, pa, pcid, g);
    else begin checks++; $display("FAIL insert_timeout: got ready=0 expected ready=1"); end
    @(posedge clk); #1;
    bus.ins_valid = 1'b0;
  endtask

  task automatic do_flush(bit all, logic [11:0] pcid);
    int busy_n = 0;
    bit rdy = 0;
    @(posedge clk); #1;
    bus.flush_valid = 1'b1; bus.flush_all = all; bus.flush_pcid = pcid;
    @(negedge clk);
    chk("flush_idle_at_start", 64'(bus.flush_busy), 64'h0);
    m_flush(all, pcid);
    @(posedge clk); #1;
    bus.flush_valid = 1'b0;
    for (int i = 0; i < SETS + 4; i++) begin
      @(negedge clk);
      if (bus.flush_busy) begin
        busy_n++;
        if (bus.req_ready || bus.ins_ready) rdy = 1;
      end
    end
    chk("flush_busy_cycles", 64'(busy_n), 64'(SETS));
    chk("ready_while_busy", 64'(rdy), 64'h0);
  endtask

  function automatic logic [63:0] set0_va(int t);
    return 64'(t) << (PAGE_BITS + IDX_W);
  endfunction

  function automatic logic [63:0] rand_va();
    logic [63:0] va;
    va = (64'($urandom_range(0, 5)) << (PAGE_BITS + IDX_W)) |
         (64'($urandom_range(0, 3)) << PAGE_BITS) | 64'($urandom_range(0, 4095));
    if ($urandom_range(0, 7) == 0) va[63] = 1'b1;
    return va;
  endfunction

  initial begin
    bus.req_valid = 1'b0; bus.req_va = '0; bus.req_pcid = '0;
    bus.ins_valid = 1'b0; bus.ins_va = '0; bus.ins_pa = '0;
    bus.ins_pcid = '0; bus.ins_global = 1'b0;
    bus.flush_valid = 1'b0; bus.flush_all = 1'b0; bus.flush_pcid = '0;
    shutdown_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    chk("rst_resp_miss", 64'(bus.resp_miss), 64'h0);
    chk("rst_resp_pa", bus.resp_pa, 64'h0);
    chk("rst_flush_busy", 64'(bus.flush_busy), 64'h0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_ins_ready", 64'(bus.ins_ready), 64'h0);
    @(posedge clk); #1;
    shutdown_n = 1'b1;

    // Empty TLB misses, including top-of-space address.
    do_lookup(64'hFFFF_FFFF_FFFF_FFF1, 12'd0);
    // Basic fill and PCID qualification.
    do_insert(64'h1000, 64'hABCD_E000, 12'd1, 1'b0);
    do_lookup(64'h1123, 12'd1);
    do_lookup(64'h1123, 12'd0);
    // Nine tags into set 0: first one evicted by PLRU.
    for (int t = 0; t < 9; t++) do_insert(set0_va(t), 64'(t + 1) << 20, 12'd1, 1'b0);
    for (int t = 0; t < 9; t++) do_lookup(set0_va(t) | 64'h45, 12'd1);
    // Re-insert existing mapping: overwritten in place, no way lost.
    do_insert(set0_va(5), 64'h5555_5000, 12'd1, 1'b0);
    for (int t = 1; t < 9; t++) do_lookup(set0_va(t) | 64'h7, 12'd1);
    // Per-PCID flush keeps other PCIDs.
    do_insert(64'h2000, 64'h2222_2000, 12'd2, 1'b0);
    do_insert(set0_va(3), 64'h3333_3000, 12'd2, 1'b0);
    do_flush(1'b0, 12'd1);
    do_lookup(64'h1010, 12'd1);
    do_lookup(set0_va(6), 12'd1);
    do_lookup(64'h2010, 12'd2);
    do_lookup(set0_va(3), 12'd2);
`ifdef TLB_GLOBAL_EN
    do_insert(64'h3000, 64'h7777_7000, 12'd3, 1'b1);
    do_lookup(64'h3001, 12'd9);
    do_flush(1'b0, 12'd3);
    do_lookup(64'h3002, 12'd4);
    do_flush(1'b1, 12'd0);
    do_lookup(64'h3003, 12'd3);
`endif

    // Reset in the middle of a flush.
    do_insert(64'h4000, 64'h4444_4000, 12'd5, 1'b0);
    @(posedge clk); #1;
    bus.flush_valid = 1'b1; bus.flush_all = 1'b1;
    @(posedge clk); #1;
    bus.flush_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    shutdown_n = 1'b0;
    #1;
    chk("midflush_rst_busy", 64'(bus.flush_busy), 64'h0);
    chk("midflush_rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    m_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    shutdown_n = 1'b1;
    do_lookup(64'h4000, 12'd5);
    do_lookup(64'h2010, 12'd2);
    do_lookup(set0_va(3), 12'd2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      logic [11:0] pc = 12'($urandom_range(0, 2));
      if (r < 45) do_lookup(rand_va(), pc);
`ifdef TLB_GLOBAL_EN
      else if (r < 92) do_insert(rand_va(), {$urandom, $urandom}, pc, 1'b0);
`else
      else if (r < 92) do_insert(rand_va(), {$urandom, $urandom}, pc, 1'($urandom));
`endif
      else do_flush(1'($urandom_range(0, 3) == 0), pc);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
